// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl: frame sequencer between uart_rx and the CPU instruction/data memory.
// Frame: SYNC, BASE_LO, BASE_HI, CNT_LO, CNT_HI, CNT*BPW payload bytes (LSB first), [CHK].
// Optional feature macro: UART_LOADER_CHKSUM_EN adds a trailing CHK byte that must make the
// 8-bit sum of every byte after SYNC equal to zero; without it the frame ends after the last
// word write (or right after CNT_HI when CNT is zero).
module uart_loader_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BPW    = WORD_WIDTH / DATA_WIDTH;
  localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StBaseLo,
    StBaseHi,
    StCntLo,
    StCntHi,
`ifdef UART_LOADER_CHKSUM_EN
    StData,
    StChk
`else
    StData
`endif
  } state_e;

  state_e                r_state;
  logic                  r_rx_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WORD_WIDTH-1:0] r_mem_wdata;
  logic                  r_done;
  logic                  r_err;
  logic [7:0]            r_base_lo;
  logic [7:0]            r_cnt_lo;
  logic [15:0]           r_cnt;
  logic [15:0]           r_word_idx;
  logic [BIDX_W-1:0]     r_byte_idx;
  logic [WORD_WIDTH-1:0] r_word;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [TMO_W-1:0]      r_tmo;
`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0]            r_sum;
  logic [7:0]            w_sum_next;
`endif

  logic                             w_accept;
  logic [7:0]                       w_byte8;
  logic [15:0]                      w_hdr16;
  logic [WORD_WIDTH+DATA_WIDTH-1:0] w_shift;
  logic [WORD_WIDTH-1:0]            w_word_next;
  logic                             w_last_write_done;

  // Byte handshake and word assembly helpers
  always_comb begin
    w_accept    = rx_valid & r_rx_ready;
    w_byte8     = rx_data[7:0];
    w_hdr16     = {w_byte8, r_base_lo};
    // New byte enters at the top so the first byte of a word ends up in the LSBs.
    w_shift     = {rx_data, r_word};
    w_word_next = w_shift[WORD_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    // Cycle in which the CNT-th write strobe is on the bus.
    w_last_write_done = (r_state == StData) && r_mem_we && (r_word_idx == r_cnt);
`ifdef UART_LOADER_CHKSUM_EN
    w_sum_next  = r_sum + w_byte8;
`endif
  end

  // Frame FSM with registered outputs, counters and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_base_lo   <= '0;
      r_cnt_lo    <= '0;
      r_cnt       <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_waddr     <= '0;
      r_tmo       <= '0;
`ifdef UART_LOADER_CHKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      // One-cycle consume pulse, at most one byte per two cycles.
      r_rx_ready <= rx_valid & ~r_rx_ready;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;

      if (r_state == StIdle) begin
        r_tmo <= '0;
        if (w_accept && (w_byte8 == SYNC_BYTE)) begin
          r_err   <= 1'b0;
          r_state <= StBaseLo;
`ifdef UART_LOADER_CHKSUM_EN
          r_sum   <= '0;
`endif
        end
      end else if (w_accept) begin
        r_tmo <= '0;
`ifdef UART_LOADER_CHKSUM_EN
        r_sum <= w_sum_next;
`endif
        case (r_state)
          StBaseLo: begin
            r_base_lo <= w_byte8;
            r_state   <= StBaseHi;
          end
          StBaseHi: begin
            // Upper BASE bits beyond the address width are dropped.
            r_waddr <= ADDR_WIDTH'(w_hdr16);
            r_state <= StCntLo;
          end
          StCntLo: begin
            r_cnt_lo <= w_byte8;
            r_state  <= StCntHi;
          end
          StCntHi: begin
            r_cnt      <= {w_byte8, r_cnt_lo};
            r_word_idx <= '0;
            r_byte_idx <= '0;
            if ({w_byte8, r_cnt_lo} == 16'd0) begin
`ifdef UART_LOADER_CHKSUM_EN
              r_state <= StChk;
`else
              r_state <= StIdle;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state <= StData;
            end
          end
          StData: begin
            r_word <= w_word_next;
            if (r_byte_idx == LAST_BYTE) begin
              r_byte_idx  <= '0;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_waddr;
              r_mem_wdata <= w_word_next;
              r_waddr     <= r_waddr + ADDR_WIDTH'(1);
              r_word_idx  <= r_word_idx + 16'd1;
            end else begin
              r_byte_idx <= r_byte_idx + BIDX_W'(1);
            end
          end
`ifdef UART_LOADER_CHKSUM_EN
          StChk: begin
            r_state <= StIdle;
            if (w_sum_next == 8'h00) begin
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
`endif
          default: r_state <= StIdle;
        endcase
      end else if (w_last_write_done) begin
        // The handshake cannot accept in the cycle right after an accept, so this never
        // collides with a payload byte.
        r_tmo <= r_tmo + TMO_W'(1);
`ifdef UART_LOADER_CHKSUM_EN
        r_state <= StChk;
`else
        r_state <= StIdle;
        r_done  <= 1'b1;
`endif
      end else if (r_tmo == TMO_LAST) begin
        // Timeout: abandon the frame; any partial word is dropped.
        r_tmo   <= '0;
        r_err   <= 1'b1;
        r_state <= StIdle;
      end else begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

  // Output drive from state and registers
  always_comb begin
    rx_ready  = r_rx_ready;
    mem_we    = r_mem_we;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    busy      = (r_state != StIdle);
    done      = r_done;
    err       = r_err;
  end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// tb_uart_loader_ctrl: directed self-checking bench for uart_loader_ctrl.
// Works with or without UART_LOADER_CHKSUM_EN; the checksum byte is appended when defined.
module tb_uart_loader_ctrl;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_ready  = 0;
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  fq[$];

  uart_loader_ctrl #(
    .DATA_WIDTH     (8),
    .WORD_WIDTH     (32),
    .ADDR_WIDTH     (10),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Log writes, done pulses and consume pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      if (done) n_done++;
      if (rx_ready) n_ready++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    n_done  = 0;
    n_ready = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present a byte and hold it until the consume pulse has been seen
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Send fq; with checksum enabled append the byte zeroing the post-SYNC sum, plus adj
  task automatic send_frame(input logic [7:0] adj);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      if (i > 0) sum = sum + fq[i];
    end
`ifdef UART_LOADER_CHKSUM_EN
    send_byte(8'h00 - sum + adj);
`else
    sum = adj;
`endif
  endtask

  function automatic logic [63:0] wa(input int k);
    return (wr_addr.size() > k) ? 64'(wr_addr[k]) : 64'hdead;
  endfunction

  function automatic logic [63:0] wd(input int k);
    return (wr_data.size() > k) ? 64'(wr_data[k]) : 64'hdead;
  endfunction

  initial begin
    // Reset state
    cycles(3);
    check_eq("rst_outputs", {rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err}, 64'h0);
    rst = 1'b0;
    cycles(2);
    check_eq("idle_busy", busy, 1'b0);

    // Two-word frame to 0x010
    clear_log();
    fq = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(8'h00);
    cycles(4);
    check_eq("a_nwr", wr_addr.size(), 2);
    check_eq("a_addr0", wa(0), 64'h010);
    check_eq("a_data0", wd(0), 64'h04030201);
    check_eq("a_addr1", wa(1), 64'h011);
    check_eq("a_data1", wd(1), 64'h08070605);
    check_eq("a_done", n_done, 1);
    check_eq("a_busy_err", {busy, err}, 2'b00);

    // Leading junk is consumed and dropped, then a one-word frame
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    cycles(2);
    check_eq("junk_ready", n_ready, 3);
    check_eq("junk_busy", busy, 1'b0);
    fq = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(8'h00);
    cycles(4);
`ifdef UART_LOADER_CHKSUM_EN
    check_eq("b_ready", n_ready, 13);
`else
    check_eq("b_ready", n_ready, 12);
`endif
    check_eq("b_nwr", wr_addr.size(), 1);
    check_eq("b_addr", wa(0), 64'h020);
    check_eq("b_data", wd(0), 64'hEFBEADDE);
    check_eq("b_done", n_done, 1);

    // Address wrap from 0x3FF to 0x000
    clear_log();
    fq = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(8'h00);
    cycles(4);
    check_eq("w_nwr", wr_addr.size(), 2);
    check_eq("w_addr0", wa(0), 64'h3FF);
    check_eq("w_data0", wd(0), 64'h44332211);
    check_eq("w_addr1", wa(1), 64'h000);
    check_eq("w_data1", wd(1), 64'h88776655);
    check_eq("w_done", n_done, 1);

    // Stall after two payload bytes until timeout
    clear_log();
    fq = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i]);
    cycles(30);
    check_eq("t_busy_pre", {busy, err}, 2'b10);
    cycles(20);
    check_eq("t_busy_err", {busy, err}, 2'b01);
    check_eq("t_nwr", wr_addr.size(), 0);
    check_eq("t_done", n_done, 0);
    send_byte(8'hA5);
    check_eq("t_sync_clr", {busy, err}, 2'b10);
    // Finish as a CNT=0 frame: done with no write
    fq = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(8'h00);
    cycles(3);
    check_eq("z_done", n_done, 1);
    check_eq("z_nwr", wr_addr.size(), 0);
    check_eq("z_busy_err", {busy, err}, 2'b00);

`ifdef UART_LOADER_CHKSUM_EN
    // Checksum off by one: word still written, err set, no done
    clear_log();
    fq = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'h01);
    cycles(3);
    check_eq("c_nwr", wr_addr.size(), 1);
    check_eq("c_addr", wa(0), 64'h030);
    check_eq("c_data", wd(0), 64'h04030201);
    check_eq("c_done", n_done, 0);
    check_eq("c_busy_err", {busy, err}, 2'b01);
`endif

    // Reset in the middle of DATA
    fq = '{8'hA5, 8'h40, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i]);
    rst = 1'b1;
    @(negedge clk);
    check_eq("r_outputs", {rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err}, 64'h0);
    rst = 1'b0;
    clear_log();
    cycles(TMO + 5);
    check_eq("r_quiet", {wr_addr.size() == 0, n_done == 0, busy, err}, 4'b1100);
    fq = '{8'hA5, 8'h50, 8'h00, 8'h01, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    send_frame(8'h00);
    cycles(4);
    check_eq("r_nwr", wr_addr.size(), 1);
    check_eq("r_addr", wa(0), 64'h050);
    check_eq("r_data", wd(0), 64'h0D0C0B0A);
    check_eq("r_done", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_loader_ctrl.md
Name: uart_loader_ctrl

Overview:
Frame sequencer between uart_rx and the instruction/data memory of the RSA pipeline CPU.
- Consumes bytes from uart_rx over its valid/ready handshake.
- Parses a load frame and assembles bytes into little-endian words.
- Writes the words to consecutive memory addresses.
- Holds the CPU via busy while a frame is in progress; reports done/err.

Parameters:
DATA_WIDTH, 8, byte width from uart_rx
WORD_WIDTH, 32, memory word width; must be a multiple of DATA_WIDTH (BPW = WORD_WIDTH/DATA_WIDTH)
ADDR_WIDTH, 10, memory word-address width
TIMEOUT_CYCLES, 100000, max idle clocks between accepted bytes inside a frame
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  DATA_WIDTH  byte from uart_rx
rx_valid  in  1  uart_rx byte available (held until consumed)
rx_ready  out  1  consume pulse to uart_rx
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  WORD_WIDTH  word data
busy  out  1  frame in progress (CPU hold)
done  out  1  one-cycle pulse: frame completed OK
err  out  1  sticky error flag

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE. rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. Counters are cleared.
- Reset mid-frame aborts the frame; no further writes occur.
- Byte accept:
  - rx_ready is registered.
  - It goes high for exactly one cycle in the cycle after rx_valid=1 is sampled while rx_ready=0.
  - The byte is accepted (rx_data captured) in the cycle rx_valid=1 and rx_ready=1.
  - Minimum spacing is one accepted byte per 2 cycles.
- Frame format: SYNC_BYTE, BASE_LO, BASE_HI, CNT_LO, CNT_HI, CNT*BPW payload bytes (LSB first per word), [CHK].
  - BASE bits above ADDR_WIDTH are ignored.
  - CNT is a 16-bit word count.
- FSM states: IDLE -> BASE_LO -> BASE_HI -> CNT_LO -> CNT_HI -> DATA -> (CHK) -> IDLE.
  - IDLE: a non-SYNC byte is accepted and discarded. A SYNC byte clears err and moves to BASE_LO.
  - Each header state advances on one accepted byte.
  - CNT_HI: if the assembled CNT=0, go to CHK (or to IDLE with a done pulse if checksum is disabled). Otherwise go to DATA.
  - DATA: shift bytes into a word register.
    - On the BPW-th byte, the next cycle drives mem_we=1 for 1 cycle, mem_addr=(BASE+word_idx) mod 2^ADDR_WIDTH, mem_wdata=assembled word.
    - word_idx then increments.
    - Address wrap-around is silent.
  - After the CNT-th word write, go to CHK (or to IDLE with done).
- busy=1 in every state except IDLE.
- done=1 for one cycle in the cycle after the frame ends successfully (after the final write or the CHK byte).
- Timeout:
  - The counter clears on every accepted byte and on entering BASE_LO.
  - It increments each cycle in non-IDLE states.
  - On reaching TIMEOUT_CYCLES: err=1, go to IDLE, no done pulse.
  - A partially assembled word is not written.
- err stays high until the next SYNC byte is accepted in IDLE, or reset.
- No rollback: words already written stay written on error.

Optional Feature:
UART_LOADER_CHKSUM_EN
- Defined: CHK state present.
  - Running 8-bit sum of all bytes after SYNC (header + payload), mod 256.
  - The CHK byte must make the total sum 0 mod 256.
  - Match: done pulse. Mismatch: err=1, no done pulse.
  - Timeout also applies while waiting in CHK.
- Undefined: no CHK state, no checksum logic. The frame ends after the last word write, or after CNT_HI when CNT=0.

Test Plan:
- Reset, then frame A5 10 00 02 00 + 8 bytes 01..08 (+ chk) -> two writes: addr 0x010 data 0x04030201, addr 0x011 data 0x08070605. done pulses once; busy low afterwards; err=0.
- Bytes 00 FF 3C in IDLE, then a valid 1-word frame -> leading bytes discarded, each with a rx_ready pulse. Exactly one write; done=1.
- Frame with BASE=0x03FF, CNT=2 -> writes to 0x3FF then 0x000 (wrap).
- Frame stalls after 2 payload bytes for TIMEOUT_CYCLES -> no write, err=1, busy=0, no done. Next SYNC clears err.
- Checksum enabled, CHK byte off by one -> all payload words written, err=1, no done.
- Checksum disabled, CNT=0 frame -> done pulses after CNT_HI.
- rst asserted mid-DATA -> all outputs 0 next cycle. Next frame loads correctly.
